// File: rtl/sc_mmio_pkg.sv
// Shared word-map constants and parameter limits for the MMIO port bank.
package sc_mmio_pkg;

    localparam logic [4:0] OUT_BASE   = 5'h00;
    localparam logic [4:0] IN_BASE    = 5'h10;
    localparam logic [4:0] MASK_OFF   = 5'h1E;
    localparam logic [4:0] STATUS_OFF = 5'h1F;

    localparam int MAX_OUT = 16;
    localparam int MAX_IN  = 14;

endpackage

// File: rtl/sc_io_sync_chan.sv
// One input channel: three-flop synchroniser plus a raw change flag (s2 vs s3).
module sc_io_sync_chan
    import sc_mmio_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] async_i,
    output logic [DATA_W-1:0] sync_o,
    output logic              changed_o
);

    logic [DATA_W-1:0] s1_q;
    logic [DATA_W-1:0] s2_q;
    logic [DATA_W-1:0] s3_q;

    // Synchroniser shift chain; s3 only exists to detect edges on s2.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_q <= {DATA_W{1'b0}};
            s2_q <= {DATA_W{1'b0}};
            s3_q <= {DATA_W{1'b0}};
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync_o    = s2_q;
    assign changed_o = (s2_q != s3_q);

endmodule

// File: rtl/sc_mmio_port_bank.sv
// MMIO bank: N_OUT output registers, N_IN synchronised inputs with sticky
// change status, interrupt mask and a registered one-cycle-latency read port.
module sc_mmio_port_bank
    import sc_mmio_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_OUT  = 3,
    parameter int N_IN   = 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    sel,
    input  logic [6:0]              addr,
    input  logic                    we,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rdata,
    output logic                    rvalid,
    output logic [N_OUT*DATA_W-1:0] out_ports,
    input  logic [N_IN*DATA_W-1:0]  in_ports,
    output logic                    irq
);

    if (N_OUT < 1 || N_OUT > MAX_OUT || N_IN < 1 || N_IN > MAX_IN) begin : g_param_check
        $error("sc_mmio_port_bank: N_OUT or N_IN outside legal range");
    end

    logic [DATA_W-1:0] out_q [N_OUT];
    logic [DATA_W-1:0] out_d [N_OUT];
    logic [N_IN-1:0]   mask_q, mask_d;
    logic [N_IN-1:0]   status_q, status_d;
    logic [1:0]        arm_q, arm_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              irq_q, irq_d;

    logic [4:0]        word_s;
    logic              wr_s;
    logic              rd_s;
    logic [DATA_W-1:0] rmux_s;
    logic [N_IN-1:0]   chg_s;
    logic [N_IN-1:0]   w1c_s;
    logic [N_IN-1:0]   set_s;
    logic [DATA_W-1:0] in_sync_s [N_IN];
    logic              unused_s;

    assign word_s   = addr[6:2];
    assign wr_s     = sel & we;
    assign rd_s     = sel & rd_en;
    assign unused_s = ^addr[1:0];

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        sc_io_sync_chan #(.DATA_W(DATA_W)) u_sync (
            .clock    (clock),
            .resetn   (resetn),
            .async_i  (in_ports[g*DATA_W +: DATA_W]),
            .sync_o   (in_sync_s[g]),
            .changed_o(chg_s[g])
        );
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_ports[g*DATA_W +: DATA_W] = out_q[g];
    end

    // Read mux over pre-write state; unmapped words fall through to zero.
    always_comb begin
        rmux_s = {DATA_W{1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            rmux_s = (word_s == (OUT_BASE + 5'(i))) ? out_q[i] : rmux_s;
        end
        for (int i = 0; i < N_IN; i++) begin
            rmux_s = (word_s == (IN_BASE + 5'(i))) ? in_sync_s[i] : rmux_s;
        end
        rmux_s = (word_s == MASK_OFF)   ? DATA_W'(mask_q)   : rmux_s;
        rmux_s = (word_s == STATUS_OFF) ? DATA_W'(status_q) : rmux_s;
    end

    // Next state; a change detected on the same edge as a W1C keeps the bit set.
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            out_d[i] = (wr_s && (word_s == (OUT_BASE + 5'(i)))) ? wdata : out_q[i];
        end
        mask_d   = (wr_s && (word_s == MASK_OFF))   ? wdata[N_IN-1:0] : mask_q;
        w1c_s    = (wr_s && (word_s == STATUS_OFF)) ? wdata[N_IN-1:0] : {N_IN{1'b0}};
        set_s    = (arm_q == 2'd3) ? chg_s : {N_IN{1'b0}};
        status_d = (status_q & ~w1c_s) | set_s;
        arm_d    = (arm_q == 2'd3) ? arm_q : (arm_q + 2'd1);
        rvalid_d = rd_s;
        rdata_d  = rd_s ? rmux_s : rdata_q;
        irq_d    = |(status_q & mask_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < N_OUT; i++) begin
                out_q[i] <= {DATA_W{1'b0}};
            end
            mask_q   <= {N_IN{1'b0}};
            status_q <= {N_IN{1'b0}};
            arm_q    <= 2'd0;
            rdata_q  <= {DATA_W{1'b0}};
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                out_q[i] <= out_d[i];
            end
            mask_q   <= mask_d;
            status_q <= status_d;
            arm_q    <= arm_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_sc_mmio_port_bank.sv
// Self-checking bench: directed scenarios plus random traffic against a
// delay-line behavioural model of the bank.
module tb_sc_mmio_port_bank;

    localparam int DW = 32;
    localparam int NO = 3;
    localparam int NI = 2;

    logic             clock;
    logic             resetn;
    logic             sel;
    logic [6:0]       addr;
    logic             we;
    logic [DW-1:0]    wdata;
    logic             rd_en;
    logic [DW-1:0]    rdata;
    logic             rvalid;
    logic [NO*DW-1:0] out_ports;
    logic [NI*DW-1:0] in_ports;
    logic             irq;

    int n_checks = 0;
    int n_fail   = 0;

    sc_mmio_port_bank #(.DATA_W(DW), .N_OUT(NO), .N_IN(NI)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .sel      (sel),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .rd_en    (rd_en),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .out_ports(out_ports),
        .in_ports (in_ports),
        .irq      (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: hist[k] is the input sampled k+1 edges ago.
    logic [DW-1:0]    m_out [NO];
    logic [NI-1:0]    m_mask;
    logic [NI-1:0]    m_status;
    logic             m_irq;
    logic             m_rvalid;
    logic [DW-1:0]    m_rdata;
    logic [NI*DW-1:0] m_hist [3];
    int               m_rel;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input int wi);
        if (wi < NO) return m_out[wi];
        if (wi >= 16 && wi < 16 + NI) return m_hist[1][(wi-16)*DW +: DW];
        if (wi == 30) return DW'(m_mask);
        if (wi == 31) return DW'(m_status);
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NO; i++) m_out[i] = '0;
        m_mask = '0; m_status = '0; m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        for (int k = 0; k < 3; k++) m_hist[k] = '0;
        m_rel = 0;
    endtask

    task automatic model_edge();
        int            wi;
        logic [NI-1:0] chg;
        logic [NI-1:0] w1c;
        logic [DW-1:0] rv;
        if (!resetn) begin
            model_reset();
            return;
        end
        wi = int'(addr[6:2]);
        rv = model_read(wi);
        for (int i = 0; i < NI; i++) chg[i] = (m_hist[1][i*DW +: DW] != m_hist[2][i*DW +: DW]);
        m_irq    = |(m_status & m_mask);
        m_rvalid = sel && rd_en;
        if (m_rvalid) m_rdata = rv;
        w1c = '0;
        if (sel && we) begin
            if (wi < NO) m_out[wi] = wdata;
            else if (wi == 30) m_mask = wdata[NI-1:0];
            else if (wi == 31) w1c = wdata[NI-1:0];
        end
        m_status = (m_status & ~w1c) | ((m_rel >= 3) ? chg : '0);
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = in_ports;
        if (m_rel < 3) m_rel++;
    endtask

    task automatic tick();
        logic [NO*DW-1:0] exp_out;
        model_edge();
        @(posedge clock);
        #1;
        for (int i = 0; i < NO; i++) exp_out[i*DW +: DW] = m_out[i];
        check_eq("rvalid", 128'(rvalid), 128'(m_rvalid));
        check_eq("rdata", 128'(rdata), 128'(m_rdata));
        check_eq("irq", 128'(irq), 128'(m_irq));
        check_eq("out_ports", 128'(out_ports), 128'(exp_out));
    endtask

    task automatic idle();
        sel = 1'b0; we = 1'b0; rd_en = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [4:0] w, input logic [DW-1:0] d);
        sel = 1'b1; we = 1'b1; rd_en = 1'b0; addr = {w, 2'b00}; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] w);
        sel = 1'b1; we = 1'b0; rd_en = 1'b1; addr = {w, 2'b00};
        tick();
        sel = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        logic [4:0] picks [7];
        logic [4:0] w;
        picks[0] = 5'h00; picks[1] = 5'h01; picks[2] = 5'h02; picks[3] = 5'h10;
        picks[4] = 5'h11; picks[5] = 5'h1E; picks[6] = 5'h1F;

        resetn = 1'b0; sel = 1'b0; we = 1'b0; rd_en = 1'b0;
        addr = 7'd0; wdata = '0; in_ports = '0;
        model_reset();

        // 1: reset state, writes, single read
        idle(); idle();
        check_eq("rst_rvalid", 128'(rvalid), 128'(1'b0));
        check_eq("rst_out", 128'(out_ports), 128'(0));
        resetn = 1'b1;
        idle();
        wr(5'h00, 32'h12345678);
        check_eq("t1_out0", 128'(out_ports[31:0]), 128'(32'h12345678));
        wr(5'h02, 32'hCAFEF00D);
        check_eq("t1_out2", 128'(out_ports[95:64]), 128'(32'hCAFEF00D));
        rd(5'h02);
        check_eq("t1_rdata", 128'(rdata), 128'(32'hCAFEF00D));
        check_eq("t1_rvalid", 128'(rvalid), 128'(1'b1));
        idle();
        check_eq("t1_rvalid_drop", 128'(rvalid), 128'(1'b0));

        // 2: input change sets STATUS at edge 3, irq one edge later
        wr(5'h1E, 32'h2);
        in_ports[63:32] = 32'h000000A5;
        idle(); idle(); idle();
        check_eq("t2_irq_lag", 128'(irq), 128'(1'b0));
        idle();
        check_eq("t2_irq", 128'(irq), 128'(1'b1));
        rd(5'h1F);
        check_eq("t2_status", 128'(rdata), 128'(32'h2));
        rd(5'h11);
        check_eq("t2_in1", 128'(rdata), 128'(32'hA5));

        // 3: set beats W1C on the same edge; quiet W1C clears
        in_ports[63:32] = 32'h0000005A;
        idle(); idle();
        wr(5'h1F, 32'h2);
        rd(5'h1F);
        check_eq("t3_set_wins", 128'(rdata), 128'(32'h2));
        wr(5'h1F, 32'h2);
        idle();
        check_eq("t3_irq_clr", 128'(irq), 128'(1'b0));
        rd(5'h1F);
        check_eq("t3_status_clr", 128'(rdata), 128'(32'h0));

        // 4: same-cycle read and write return the pre-write value
        wr(5'h01, 32'h5);
        sel = 1'b1; we = 1'b1; rd_en = 1'b1; addr = {5'h01, 2'b00}; wdata = 32'h9;
        tick();
        check_eq("t4_rw_old", 128'(rdata), 128'(32'h5));
        rd(5'h01);
        check_eq("t4_rw_new", 128'(rdata), 128'(32'h9));
        in_ports[31:0] = 32'h1;
        idle(); idle(); idle();
        sel = 1'b1; we = 1'b1; rd_en = 1'b1; addr = {5'h1F, 2'b00}; wdata = 32'h1;
        tick();
        check_eq("t4_status_preclr", 128'(rdata), 128'(32'h1));
        rd(5'h1F);
        check_eq("t4_status_postclr", 128'(rdata), 128'(32'h0));

        // 5: inputs held high through reset must not set STATUS
        in_ports = '1;
        resetn = 1'b0;
        idle(); idle();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) idle();
        rd(5'h1F);
        check_eq("t5_status_quiet", 128'(rdata), 128'(32'h0));
        rd(5'h1C);
        check_eq("t5_unmapped_rd", 128'(rdata), 128'(32'h0));
        check_eq("t5_unmapped_rv", 128'(rvalid), 128'(1'b1));
        wr(5'h10, 32'h1234);
        rd(5'h10);
        check_eq("t5_in_ro", 128'(rdata), 128'(32'hFFFFFFFF));

        // 6: reset right after a read discards it
        wr(5'h00, 32'hDEADBEEF);
        rd(5'h00);
        check_eq("t6_rd", 128'(rdata), 128'(32'hDEADBEEF));
        resetn = 1'b0;
        idle();
        check_eq("t6_rvalid", 128'(rvalid), 128'(1'b0));
        check_eq("t6_rdata", 128'(rdata), 128'(0));
        check_eq("t6_out", 128'(out_ports), 128'(0));
        resetn = 1'b1;

        // random traffic checked every cycle by tick()
        for (int n = 0; n < 800; n++) begin
            resetn = ($urandom_range(0, 199) != 0);
            sel    = ($urandom_range(0, 3) != 0);
            we     = $urandom_range(0, 1) == 1;
            rd_en  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1) w = picks[$urandom_range(0, 6)];
            else w = 5'($urandom_range(0, 31));
            addr  = {w, 2'($urandom_range(0, 3))};
            wdata = $urandom;
            if ($urandom_range(0, 5) == 0) in_ports[31:0] = $urandom;
            if ($urandom_range(0, 5) == 0) in_ports[63:32] = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
